// File: rtl/pwm_servo_generator.sv
// Frame-periodic RC servo/ESC PWM transmitter with a one-deep command slot,
// range clamping, frame-aligned updates and a neutral-width failsafe.
module pwm_servo_generator #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int FRAME_US        = 20000,
    parameter int MIN_US          = 1000,
    parameter int MAX_US          = 2000,
    parameter int NEUTRAL_US      = 1500,
    parameter int FAILSAFE_FRAMES = 25
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [10:0] CMD_US,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        ENABLE,
    output logic        PWM_OUT,
    output logic        FRAME_START,
    output logic        CLAMPED,
    output logic        FAILSAFE
);

    localparam int PRE = CLK_HZ / 1_000_000;
    localparam int PW  = $clog2(PRE);
    localparam int MW  = $clog2(FAILSAFE_FRAMES + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(PRE - 1);
    localparam logic [14:0]   FRAME_LAST = 15'(FRAME_US - 1);
    localparam logic [10:0]   MIN_W      = 11'(MIN_US);
    localparam logic [10:0]   MAX_W      = 11'(MAX_US);
    localparam logic [10:0]   NEU_W      = 11'(NEUTRAL_US);
    localparam logic [MW-1:0] MISS_LIM   = MW'(FAILSAFE_FRAMES);
    localparam logic [MW-1:0] MISS_TRIP  = MW'(FAILSAFE_FRAMES - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [14:0]   frame_q, frame_d;
    logic [10:0]   active_q, active_d;
    logic [10:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          en_q, en_d;
    logic          pwm_q, pwm_d;
    logic          fstart_q, fstart_d;
    logic          clamped_q, clamped_d;
    logic          failsafe_q, failsafe_d;

    logic          us_tick;
    logic          boundary;
    logic          accept;
    logic          cmd_oor;
    logic [10:0]   cmd_clamp;

    always_comb begin
        us_tick  = (pre_q == PRE_LAST);
        boundary = us_tick && (frame_q == FRAME_LAST);
        accept   = CMD_VALID && !pend_full_q;
        cmd_oor  = (CMD_US < MIN_W) || (CMD_US > MAX_W);

        if (CMD_US < MIN_W) begin
            cmd_clamp = MIN_W;
        end else if (CMD_US > MAX_W) begin
            cmd_clamp = MAX_W;
        end else begin
            cmd_clamp = CMD_US;
        end
    end

    always_comb begin
        pre_d       = pre_q;
        frame_d     = frame_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        miss_d      = miss_q;
        en_d        = en_q;
        clamped_d   = clamped_q;
        failsafe_d  = failsafe_q;

        if (us_tick) begin
            pre_d   = '0;
            frame_d = (frame_q == FRAME_LAST) ? 15'd0 : frame_q + 15'd1;
        end else begin
            pre_d = pre_q + 1'b1;
        end

        // An accept is only possible with the slot empty, so the boundary
        // below never sees a command accepted in its own cycle.
        if (accept) begin
            pend_d      = cmd_clamp;
            pend_full_d = 1'b1;
            clamped_d   = cmd_oor;
        end

        if (boundary) begin
            en_d = ENABLE;
            if (pend_full_q) begin
                active_d    = pend_q;
                pend_full_d = 1'b0;
                miss_d      = '0;
                failsafe_d  = 1'b0;
            end else begin
                if (miss_q != MISS_LIM) begin
                    miss_d = miss_q + 1'b1;
                end
                if (miss_q >= MISS_TRIP) begin
                    active_d   = NEU_W;
                    failsafe_d = 1'b1;
                end
            end
        end

        fstart_d = boundary;
        pwm_d    = en_q && (frame_q < {4'b0000, active_q});
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            pre_q       <= '0;
            frame_q     <= '0;
            active_q    <= NEU_W;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            miss_q      <= '0;
            en_q        <= 1'b0;
            pwm_q       <= 1'b0;
            fstart_q    <= 1'b0;
            clamped_q   <= 1'b0;
            failsafe_q  <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            frame_q     <= frame_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            miss_q      <= miss_d;
            en_q        <= en_d;
            pwm_q       <= pwm_d;
            fstart_q    <= fstart_d;
            clamped_q   <= clamped_d;
            failsafe_q  <= failsafe_d;
        end
    end

    assign CMD_READY   = !pend_full_q;
    assign PWM_OUT     = pwm_q;
    assign FRAME_START = fstart_q;
    assign CLAMPED     = clamped_q;
    assign FAILSAFE    = failsafe_q;

endmodule
